box_cmd_rx: RTL and testbench

BOX_CMD_RX -- requirements
Module: box_cmd_rx

---
 rtl/box_cmd_pkg.sv | 45 ++++
 rtl/box_rec_decode.sv | 33 +++
 rtl/box_cmd_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_box_cmd_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/box_cmd_pkg.sv
// Shared constants, types and helpers for the box command receiver.
package box_cmd_pkg;

    localparam logic [7:0] MAGIC     = 8'hA5;
    localparam int         REC_BYTES = 6;
    localparam int         X_W       = 11;
    localparam int         Y_W       = 10;
    localparam int         C_W       = 6;
    localparam int         REC_W     = 8 * REC_BYTES;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_MAGIC = 3'd1,
        ERR_COUNT = 3'd2,
        ERR_LEN   = 3'd3,
        ERR_CSUM  = 3'd4,
        ERR_RANGE = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_BODY,
        ST_CSUM,
        ST_WAIT_END,
        ST_DRAIN
    } state_e;

    // One decoded box as it is held in the staging/pending/active banks.
    typedef struct packed {
        logic [X_W-1:0] sx;
        logic [Y_W-1:0] sy;
        logic [X_W-1:0] ex;
        logic [Y_W-1:0] ey;
        logic [23:0]    rgb;
    } box_t;

    // Keep the lowest non-zero error code seen so far in a packet.
    function automatic err_e err_merge(input err_e cur, input err_e hit);
        if (hit == ERR_NONE) return cur;
        if (cur == ERR_NONE) return hit;
        return (hit < cur) ? hit : cur;
    endfunction

endpackage

// File: rtl/box_rec_decode.sv
// Combinational decode of one 48-bit big-endian box record.
module box_rec_decode
    import box_cmd_pkg::*;
#(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720
) (
    input  logic [REC_W-1:0] rec,
    output logic [X_W-1:0]   start_x,
    output logic [Y_W-1:0]   start_y,
    output logic [X_W-1:0]   end_x,
    output logic [Y_W-1:0]   end_y,
    output logic [23:0]      rgb,
    output logic             range_ok
);

    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;
    localparam logic [X_W:0] H_LIM = XW1'(H_ACT);
    localparam logic [Y_W:0] V_LIM = YW1'(V_ACT);

    assign start_x = rec[47:37];
    assign start_y = rec[36:27];
    assign end_x   = rec[26:16];
    assign end_y   = rec[15:6];

    // Each 2-bit channel is replicated to fill 8 bits (2'b10 -> 8'hAA).
    assign rgb = {{4{rec[5:4]}}, {4{rec[3:2]}}, {4{rec[1:0]}}};

    assign range_ok = (start_x <= end_x) && ({1'b0, end_x} < H_LIM) &&
                      (start_y <= end_y) && ({1'b0, end_y} < V_LIM);

endmodule

// File: rtl/box_cmd_rx.sv
// UDP box-command parser: validates packets, stages records, and commits
// the last good packet to the active outputs at the next frame start.
module box_cmd_rx
    import box_cmd_pkg::*;
#(
    parameter int BOX_NUM = 1,
    parameter int H_ACT   = 1280,
    parameter int V_ACT   = 720
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic [15:0]            rx_len,
    input  logic                   rx_end,
    input  logic                   frame_sync,
    output logic [BOX_NUM*X_W-1:0] start_xs,
    output logic [BOX_NUM*X_W-1:0] end_xs,
    output logic [BOX_NUM*Y_W-1:0] start_ys,
    output logic [BOX_NUM*Y_W-1:0] end_ys,
    output logic [BOX_NUM*24-1:0]  colors,
    output logic [BOX_NUM-1:0]     box_valid,
    output logic                   cmd_ok,
    output logic                   cmd_err,
    output logic [2:0]             err_code,
    output logic                   busy
);

    localparam logic [7:0] BOX_NUM_B = 8'(BOX_NUM);
    localparam logic [2:0] LAST_BYTE = 3'(REC_BYTES - 1);

    state_e state_reg, state_next, state_byte;
    err_e   err_reg, err_next, err_final, err_code_reg;

    logic [7:0]  xor_reg, n_reg, rec_idx_reg;
    logic [2:0]  rec_byte_reg;
    logic [39:0] rec_sh_reg;
    logic [15:0] byte_cnt_reg, byte_cnt_next;
    logic        resync_reg;
    logic        byte_ok, rec_done, fin_ok, fin_err, commit;
    logic        cmd_ok_reg, cmd_err_reg, pend_flag_reg;

    logic [BOX_NUM-1:0] pend_mask_reg, box_valid_reg, n_mask;
    box_t stage_reg [BOX_NUM];
    box_t pend_reg  [BOX_NUM];
    box_t act_reg   [BOX_NUM];

    logic [X_W-1:0] dec_sx, dec_ex;
    logic [Y_W-1:0] dec_sy, dec_ey;
    logic [23:0]    dec_rgb;
    logic           dec_range_ok;
    box_t           dec_box;

    // The record completes on its sixth byte, so decode the live byte too.
    box_rec_decode #(.H_ACT(H_ACT), .V_ACT(V_ACT)) u_dec (
        .rec      ({rec_sh_reg, rx_data}),
        .start_x  (dec_sx),
        .start_y  (dec_sy),
        .end_x    (dec_ex),
        .end_y    (dec_ey),
        .rgb      (dec_rgb),
        .range_ok (dec_range_ok)
    );
    assign dec_box = {dec_sx, dec_sy, dec_ex, dec_ey, dec_rgb};

    // Bytes after reset are discarded until the interrupted packet ends.
    assign byte_ok = rx_valid && !resync_reg;
    assign commit  = frame_sync && pend_flag_reg && !fin_ok;

    // Next state: process the byte first, then apply end-of-packet handling.
    always_comb begin
        state_byte    = state_reg;
        state_next    = state_reg;
        err_next      = err_reg;
        err_final     = err_reg;
        byte_cnt_next = byte_cnt_reg;
        rec_done      = 1'b0;
        fin_ok        = 1'b0;
        fin_err       = 1'b0;
        if (byte_ok) begin
            if (state_reg == ST_IDLE)
                byte_cnt_next = 16'd1;
            else if (byte_cnt_reg != 16'hFFFF)
                byte_cnt_next = byte_cnt_reg + 16'd1;
            case (state_reg)
                ST_IDLE: begin
                    if (rx_data == MAGIC) begin
                        state_byte = ST_COUNT;
                    end else begin
                        state_byte = ST_DRAIN;
                        err_next   = err_merge(err_reg, ERR_MAGIC);
                    end
                end
                ST_COUNT: begin
                    if (rx_data > BOX_NUM_B) begin
                        state_byte = ST_DRAIN;
                        err_next   = err_merge(err_reg, ERR_COUNT);
                    end else begin
                        if (rx_len != (16'(rx_data) * 16'd6 + 16'd3))
                            err_next = err_merge(err_reg, ERR_LEN);
                        state_byte = (rx_data == 8'd0) ? ST_CSUM : ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (rec_byte_reg == LAST_BYTE) begin
                        rec_done = 1'b1;
                        if (!dec_range_ok)
                            err_next = err_merge(err_reg, ERR_RANGE);
                        if (rec_idx_reg == n_reg - 8'd1)
                            state_byte = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (rx_data != xor_reg)
                        err_next = err_merge(err_reg, ERR_CSUM);
                    state_byte = ST_WAIT_END;
                end
                ST_WAIT_END: err_next = err_merge(err_reg, ERR_LEN);
                default: ;
            endcase
        end
        state_next = state_byte;
        err_final  = err_next;
        if (rx_end && !resync_reg && state_byte != ST_IDLE) begin
            if (state_byte == ST_COUNT || state_byte == ST_BODY || state_byte == ST_CSUM)
                err_final = err_merge(err_final, ERR_LEN);
            if (state_byte == ST_WAIT_END && byte_cnt_next != rx_len)
                err_final = err_merge(err_final, ERR_LEN);
            fin_ok     = (err_final == ERR_NONE);
            fin_err    = (err_final != ERR_NONE);
            state_next = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Parser datapath: XOR, counters, record shifter, status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg      <= ERR_NONE;
            err_code_reg <= ERR_NONE;
            xor_reg      <= 8'd0;
            n_reg        <= 8'd0;
            rec_idx_reg  <= 8'd0;
            rec_byte_reg <= 3'd0;
            rec_sh_reg   <= 40'd0;
            byte_cnt_reg <= 16'd0;
            resync_reg   <= 1'b1;
            cmd_ok_reg   <= 1'b0;
            cmd_err_reg  <= 1'b0;
        end else begin
            err_reg      <= (state_next == ST_IDLE) ? ERR_NONE : err_next;
            byte_cnt_reg <= byte_cnt_next;
            if (byte_ok) begin
                xor_reg    <= (state_reg == ST_IDLE) ? rx_data : (xor_reg ^ rx_data);
                rec_sh_reg <= {rec_sh_reg[31:0], rx_data};
                if (state_reg == ST_COUNT) begin
                    n_reg        <= rx_data;
                    rec_idx_reg  <= 8'd0;
                    rec_byte_reg <= 3'd0;
                end
                if (state_reg == ST_BODY)
                    rec_byte_reg <= (rec_byte_reg == LAST_BYTE) ? 3'd0 : rec_byte_reg + 3'd1;
            end
            if (rec_done)
                rec_idx_reg <= rec_idx_reg + 8'd1;
            if (rx_end)
                resync_reg <= 1'b0;
            cmd_ok_reg  <= fin_ok;
            cmd_err_reg <= fin_err;
            if (fin_err)
                err_code_reg <= err_final;
        end
    end

    // Pending flag/mask and the committed valid mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_mask_reg <= '0;
            pend_flag_reg <= 1'b0;
            box_valid_reg <= '0;
        end else begin
            if (fin_ok) begin
                pend_mask_reg <= n_mask;
                pend_flag_reg <= 1'b1;
            end else if (commit) begin
                pend_flag_reg <= 1'b0;
            end
            if (commit)
                box_valid_reg <= pend_mask_reg;
        end
    end

    for (genvar gi = 0; gi < BOX_NUM; gi++) begin : g_slot
        assign n_mask[gi] = (n_reg > 8'(gi));

        // Per-slot staging -> pending -> active banks.
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_reg[gi] <= '0;
                pend_reg[gi]  <= '0;
                act_reg[gi]   <= '0;
            end else begin
                if (rec_done && rec_idx_reg == 8'(gi))
                    stage_reg[gi] <= dec_box;
                if (fin_ok && n_mask[gi])
                    pend_reg[gi] <= stage_reg[gi];
                if (commit)
                    act_reg[gi] <= pend_reg[gi];
            end
        end

        assign start_xs[gi*X_W +: X_W] = act_reg[gi].sx;
        assign start_ys[gi*Y_W +: Y_W] = act_reg[gi].sy;
        assign end_xs[gi*X_W +: X_W]   = act_reg[gi].ex;
        assign end_ys[gi*Y_W +: Y_W]   = act_reg[gi].ey;
        assign colors[gi*24 +: 24]     = act_reg[gi].rgb;
    end

    assign box_valid = box_valid_reg;
    assign cmd_ok    = cmd_ok_reg;
    assign cmd_err   = cmd_err_reg;
    assign err_code  = err_code_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_box_cmd_rx.sv
// Directed bench for box_cmd_rx with BOX_NUM=2.
module tb_box_cmd_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [15:0] rx_len = 16'd0;
    logic        rx_end = 1'b0;
    logic        frame_sync = 1'b0;
    logic [21:0] start_xs, end_xs;
    logic [19:0] start_ys, end_ys;
    logic [47:0] colors;
    logic [1:0]  box_valid;
    logic        cmd_ok, cmd_err, busy;
    logic [2:0]  err_code;

    int total = 0;
    int bad = 0;

    logic [7:0]  pkt [0:15];
    logic [47:0] recs [0:1];
    logic [7:0]  t1 [0:8];
    bit          ok, er;

    box_cmd_rx #(.BOX_NUM(2), .H_ACT(1280), .V_ACT(720)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_len(rx_len), .rx_end(rx_end), .frame_sync(frame_sync),
        .start_xs(start_xs), .end_xs(end_xs), .start_ys(start_ys), .end_ys(end_ys),
        .colors(colors), .box_valid(box_valid), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mkrec(input int sx, input int sy, input int ex,
                                          input int ey, input logic [5:0] c);
        return {11'(sx), 10'(sy), 11'(ex), 10'(ey), c};
    endfunction

    // Assemble magic, count, records and trailing XOR into pkt.
    task automatic build(input int nb);
        logic [7:0] cs;
        int idx;
        pkt[0] = 8'hA5;
        pkt[1] = 8'(nb);
        cs = pkt[0] ^ pkt[1];
        idx = 2;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 6; k++) begin
                pkt[idx] = recs[b][47-8*k -: 8];
                cs = cs ^ pkt[idx];
                idx++;
            end
        end
        pkt[idx] = cs;
    endtask

    task automatic load_t1();
        for (int i = 0; i < 9; i++) pkt[i] = t1[i];
    endtask

    // Stream n bytes, rx_end on the last; return the status pulses one cycle later.
    task automatic send(input int n, input logic [15:0] len, input bit fs_last,
                        output bit o_ok, output bit o_err);
        rx_len = len;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid   = 1'b1;
            rx_data    = pkt[i];
            rx_end     = (i == n - 1);
            frame_sync = fs_last && (i == n - 1);
        end
        @(negedge clk);
        rx_valid   = 1'b0;
        rx_end     = 1'b0;
        frame_sync = 1'b0;
        o_ok  = cmd_ok;
        o_err = cmd_err;
        $display("packet n=%0d len=%0d ok=%0b err=%0b code=%0d", n, len, o_ok, o_err, err_code);
    endtask

    task automatic fsync();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        $display("frame_sync box_valid=%b", box_valid);
    endtask

    initial begin
        t1 = '{8'hA5, 8'h01, 8'h0C, 8'h81, 8'h90, 8'hC8, 8'h0F, 8'h30, 8'h4E};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_box_valid", 64'(box_valid), 64'd0);
        chk("rst_start_xs", 64'(start_xs), 64'd0);
        chk("rst_colors", 64'(colors), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ok", 64'(cmd_ok), 64'd0);

        // End-of-packet marker releases the post-reset resync.
        rx_end = 1'b1;
        @(negedge clk);
        rx_end = 1'b0;

        // Good single-box packet, committed at frame_sync.
        load_t1();
        send(9, 16'd9, 1'b0, ok, er);
        chk("t1_ok", 64'(ok), 64'd1);
        chk("t1_err", 64'(er), 64'd0);
        chk("t1_hold_before_fs", 64'(box_valid), 64'd0);
        fsync();
        chk("t1_box_valid", 64'(box_valid), 64'd1);
        chk("t1_start_x", 64'(start_xs[10:0]), 64'd100);
        chk("t1_start_y", 64'(start_ys[9:0]), 64'd50);
        chk("t1_end_x", 64'(end_xs[10:0]), 64'd200);
        chk("t1_end_y", 64'(end_ys[9:0]), 64'd60);
        chk("t1_color", 64'(colors[23:0]), 64'hFF0000);

        // Inverted checksum.
        load_t1();
        pkt[8] = ~pkt[8];
        send(9, 16'd9, 1'b0, ok, er);
        chk("csum_err", 64'(er), 64'd1);
        chk("csum_ok", 64'(ok), 64'd0);
        chk("csum_code", 64'(err_code), 64'd4);
        fsync();
        chk("csum_keep_x", 64'(start_xs[10:0]), 64'd100);
        chk("csum_keep_valid", 64'(box_valid), 64'd1);

        // Count above BOX_NUM, then bad magic.
        pkt[0] = 8'hA5; pkt[1] = 8'h03; pkt[2] = 8'hA6;
        send(3, 16'd3, 1'b0, ok, er);
        chk("count_err", 64'(er), 64'd1);
        chk("count_code", 64'(err_code), 64'd2);
        load_t1();
        pkt[0] = 8'h00;
        send(9, 16'd9, 1'b0, ok, er);
        chk("magic_code", 64'(err_code), 64'd1);

        // end_x = H_ACT is out of range.
        recs[0] = mkrec(0, 0, 1280, 0, 6'b0);
        build(1);
        send(9, 16'd9, 1'b0, ok, er);
        chk("range_err", 64'(er), 64'd1);
        chk("range_code", 64'(err_code), 64'd5);

        // Range and checksum errors together: checksum (lower) wins.
        pkt[8] = pkt[8] ^ 8'hFF;
        send(9, 16'd9, 1'b0, ok, er);
        chk("lowest_code", 64'(err_code), 64'd4);

        // Length mismatch, then rx_end before the checksum byte.
        load_t1();
        send(9, 16'd10, 1'b0, ok, er);
        chk("len_code", 64'(err_code), 64'd3);
        send(4, 16'd9, 1'b0, ok, er);
        chk("early_end_err", 64'(er), 64'd1);
        chk("early_end_code", 64'(err_code), 64'd3);
        chk("early_end_busy", 64'(busy), 64'd0);

        // Two good packets before one frame_sync: the second wins.
        recs[0] = mkrec(10, 5, 20, 6, 6'b000011);
        build(1);
        send(9, 16'd9, 1'b0, ok, er);
        chk("p1_ok", 64'(ok), 64'd1);
        recs[0] = mkrec(300, 100, 400, 200, 6'b001100);
        recs[1] = mkrec(1000, 700, 1279, 719, 6'b100110);
        build(2);
        send(15, 16'd15, 1'b0, ok, er);
        chk("p2_ok", 64'(ok), 64'd1);
        fsync();
        chk("p2_box_valid", 64'(box_valid), 64'd3);
        chk("p2_start_x0", 64'(start_xs[10:0]), 64'd300);
        chk("p2_end_x1", 64'(end_xs[21:11]), 64'd1279);
        chk("p2_end_y1", 64'(end_ys[19:10]), 64'd719);
        chk("p2_color0", 64'(colors[23:0]), 64'h00FF00);
        chk("p2_color1", 64'(colors[47:24]), 64'hAA55AA);

        // Zero-box packet clears the valid mask.
        pkt[0] = 8'hA5; pkt[1] = 8'h00; pkt[2] = 8'hA5;
        send(3, 16'd3, 1'b0, ok, er);
        chk("zero_ok", 64'(ok), 64'd1);
        fsync();
        chk("zero_box_valid", 64'(box_valid), 64'd0);

        // frame_sync coincident with acceptance defers the commit.
        load_t1();
        send(9, 16'd9, 1'b1, ok, er);
        chk("defer_ok", 64'(ok), 64'd1);
        chk("defer_hold", 64'(box_valid), 64'd0);
        fsync();
        chk("defer_commit", 64'(box_valid), 64'd1);

        // Reset in the middle of a packet.
        load_t1();
        rx_len = 16'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = pkt[i];
        end
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        rx_data = pkt[4];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(box_valid), 64'd0);
        chk("mid_rst_x", 64'(start_xs), 64'd0);
        chk("mid_rst_color", 64'(colors), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        for (int i = 5; i < 9; i++) begin
            rx_data = pkt[i];
            rx_end  = (i == 8);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_end   = 1'b0;
        chk("mid_rst_no_ok", 64'(cmd_ok), 64'd0);
        chk("mid_rst_no_err", 64'(cmd_err), 64'd0);
        chk("mid_rst_busy_after", 64'(busy), 64'd0);
        send(9, 16'd9, 1'b0, ok, er);
        chk("post_rst_ok", 64'(ok), 64'd1);
        fsync();
        chk("post_rst_valid", 64'(box_valid), 64'd1);
        chk("post_rst_x", 64'(start_xs[10:0]), 64'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
